// File: rtl/instruction_memory_if.sv
// Fetch-side bus between the fetch stage (master) and the instruction memory
// responder (slave).
//   req_valid / req_ready / req_addr          : fetch request handshake, byte address
//   rsp_valid / rsp_ready / rsp_data / rsp_error : in-order response handshake
interface instruction_memory_if #(
   parameter int REGISTER_WIDTH = 32
);
   logic                      req_valid;
   logic                      req_ready;
   logic [REGISTER_WIDTH-1:0] req_addr;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [REGISTER_WIDTH-1:0] rsp_data;
   logic                      rsp_error;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_error
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_error
   );
endinterface

// File: rtl/instruction_memory.sv
// Instruction memory responder. Accepts word fetches over a valid/ready
// handshake and returns them in order after LATENCY cycles through a fixed
// pipeline feeding a credit-limited response FIFO. A separate load port writes
// program words at any time, including while rst is high.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   bus (slave modport)   : request/response handshake
//   load_enable           : write load_data to word load_address this cycle
//   load_address          : word index of the load write
//   load_data             : word to write
module instruction_memory #(
   parameter int DEPTH          = 1024,
   parameter int LATENCY        = 2,
   parameter int QUEUE_DEPTH    = LATENCY + 1,
   parameter int REGISTER_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   instruction_memory_if.slave       bus,
   input  logic                      load_enable,
   input  logic [$clog2(DEPTH)-1:0]  load_address,
   input  logic [REGISTER_WIDTH-1:0] load_data
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [REGISTER_WIDTH-1:0] NOP = REGISTER_WIDTH'(32'h0000_0013);

   logic [REGISTER_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (load_enable) mem_q[load_address] <= load_data;
   end

   // ---------------- accept and address check ----------------
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic             req_ready_int;
   logic             accept;
   logic             pop;
   logic             rsp_valid_int;
   logic             misaligned;
   logic             out_of_range;
   logic             bad_addr;
   logic [IDX_W-1:0] word_idx;

   // req_ready comes only from rst and the credit counter.
   assign req_ready_int = !rst && (outstanding_q < CNT_W'(QUEUE_DEPTH));
   assign accept        = bus.req_valid && req_ready_int;
   assign word_idx      = bus.req_addr[IDX_W+1:2];
   assign misaligned    = |bus.req_addr[1:0];

   if (REGISTER_WIDTH > IDX_W + 2) begin : g_range
      assign out_of_range = |bus.req_addr[REGISTER_WIDTH-1:IDX_W+2];
   end else begin : g_no_range
      assign out_of_range = 1'b0;
   end

   assign bad_addr = misaligned || out_of_range;

   // Read happens in the acceptance cycle; a load at the same edge lands after it.
   logic                      s0_v;
   logic [REGISTER_WIDTH-1:0] s0_data;
   logic                      s0_err;

   assign s0_v    = accept;
   assign s0_data = bad_addr ? NOP : mem_q[word_idx];
   assign s0_err  = bad_addr;

   // ---------------- latency pipeline ----------------
   // The FIFO write is the last of the LATENCY stages, so LATENCY-1 register
   // stages sit between the read and the FIFO.
   logic                      push_v;
   logic [REGISTER_WIDTH-1:0] push_data;
   logic                      push_err;

   if (LATENCY == 1) begin : g_no_pipe
      assign push_v    = s0_v;
      assign push_data = s0_data;
      assign push_err  = s0_err;
   end else begin : g_pipe
      localparam int NS = LATENCY - 1;
      logic [NS-1:0]             pv_q, pv_d;
      logic [NS-1:0]             pe_q, pe_d;
      logic [REGISTER_WIDTH-1:0] pd_q [NS];
      logic [REGISTER_WIDTH-1:0] pd_d [NS];

      always_comb begin
         pv_d    = pv_q;
         pe_d    = pe_q;
         pd_d    = pd_q;
         pv_d[0] = s0_v;
         pe_d[0] = s0_err;
         pd_d[0] = s0_data;
         for (int i = 1; i < NS; i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
            pd_d[i] = pd_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            pv_q <= '0;
            pe_q <= '0;
            pd_q <= '{default: '0};
         end else begin
            pv_q <= pv_d;
            pe_q <= pe_d;
            pd_q <= pd_d;
         end
      end

      assign push_v    = pv_q[NS-1];
      assign push_data = pd_q[NS-1];
      assign push_err  = pe_q[NS-1];
   end

   // ---------------- response FIFO ----------------
   logic [REGISTER_WIDTH-1:0] fifo_data_q [QUEUE_DEPTH];
   logic [REGISTER_WIDTH-1:0] fifo_data_d [QUEUE_DEPTH];
   logic [QUEUE_DEPTH-1:0]    fifo_err_q, fifo_err_d;
   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic                      fifo_full;

   assign fifo_full     = (count_q == CNT_W'(QUEUE_DEPTH));
   assign rsp_valid_int = !rst && (count_q != '0);
   assign pop           = rsp_valid_int && bus.rsp_ready;

   always_comb begin
      fifo_data_d   = fifo_data_q;
      fifo_err_d    = fifo_err_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;

      if (push_v) begin
         fifo_data_d[wr_ptr_q] = push_data;
         fifo_err_d[wr_ptr_q]  = push_err;
         wr_ptr_d = (wr_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_v && !pop)      count_d = count_q + 1'b1;
      else if (!push_v && pop) count_d = count_q - 1'b1;

      if (accept && !pop)      outstanding_d = outstanding_q + 1'b1;
      else if (!accept && pop) outstanding_d = outstanding_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_data_q   <= '{default: '0};
         fifo_err_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
      end else begin
         fifo_data_q   <= fifo_data_d;
         fifo_err_q    <= fifo_err_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
      end
   end

   // The credit limit means the FIFO can never be full when a word arrives.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push_v && fifo_full));

   assign bus.req_ready = req_ready_int;
   assign bus.rsp_valid = rsp_valid_int;
   assign bus.rsp_data  = rsp_valid_int ? fifo_data_q[rd_ptr_q] : '0;
   assign bus.rsp_error = rsp_valid_int ? fifo_err_q[rd_ptr_q]  : 1'b0;
endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;
   localparam int DEPTH   = 1024;
   localparam int LATENCY = 2;
   localparam int QD      = LATENCY + 1;
   localparam int W       = 32;
   localparam int IDX_W   = $clog2(DEPTH);
   localparam logic [W-1:0] NOP = 32'h0000_0013;

   logic             clk = 1'b0;
   logic             rst;
   logic             load_enable;
   logic [IDX_W-1:0] load_address;
   logic [W-1:0]     load_data;

   instruction_memory_if #(.REGISTER_WIDTH(W)) bus ();

   instruction_memory #(
      .DEPTH(DEPTH), .LATENCY(LATENCY), .QUEUE_DEPTH(QD), .REGISTER_WIDTH(W)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .load_enable(load_enable), .load_address(load_address), .load_data(load_data)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [W-1:0] data; logic err; } rsp_t;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_rsp   = 0;
   int first_acc, first_rsp;
   bit have_acc, have_rsp;

   rsp_t         sb_q[$];
   logic [W-1:0] log_data[$];
   logic         log_err[$];
   logic [W-1:0] tb_mem [DEPTH];

   bit           stall_prev = 0;
   logic [W-1:0] stall_data;
   logic         stall_err;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: expectations pushed at acceptance, compared on handshake.
   always @(negedge clk) begin
      rsp_t exp_r, got;
      logic [W-1:0] a;
      bit bad;
      if (rst) begin
         sb_q.delete();
         stall_prev = 0;
      end else begin
         if (bus.rsp_valid && !have_rsp) begin
            have_rsp = 1; first_rsp = cyc;
         end
         if (stall_prev) begin
            n_tests++;
            if (!bus.rsp_valid || bus.rsp_data !== stall_data || bus.rsp_error !== stall_err) begin
               n_fail++;
               $display("FAIL stall_stable: got v=%b d=%h e=%b, required v=1 d=%h e=%b",
                        bus.rsp_valid, bus.rsp_data, bus.rsp_error, stall_data, stall_err);
            end
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            got.data = bus.rsp_data; got.err = bus.rsp_error;
            log_data.push_back(got.data); log_err.push_back(got.err);
            n_rsp++;
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_rsp: got d=%h e=%b, required no response", got.data, got.err);
            end else begin
               exp_r = sb_q.pop_front();
               if (got !== exp_r) begin
                  n_fail++;
                  $display("FAIL rsp_order: got d=%h e=%b, required d=%h e=%b",
                           got.data, got.err, exp_r.data, exp_r.err);
               end
            end
         end
         stall_prev = bus.rsp_valid && !bus.rsp_ready;
         stall_data = bus.rsp_data;
         stall_err  = bus.rsp_error;
         if (bus.req_valid && bus.req_ready) begin
            if (!have_acc) begin have_acc = 1; first_acc = cyc; end
            a = bus.req_addr;
            bad = (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != 0);
            exp_r.err  = bad;
            exp_r.data = bad ? NOP : tb_mem[a[IDX_W+1:2]];
            sb_q.push_back(exp_r);
         end
      end
      // Model the load after the read: read-before-write at the same edge.
      if (load_enable) tb_mem[load_address] = load_data;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_drain(output bit ok);
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (sb_q.size() == 0 && !bus.rsp_valid) begin ok = 1; break; end
      end
      tick();
   endtask

   task automatic clear_log();
      log_data.delete(); log_err.delete();
      have_acc = 0; have_rsp = 0;
   endtask

   // Reset values while rst is held, with program words loaded during reset.
   task automatic test_reset();
      for (int i = 0; i < 8; i++) begin
         load_enable = 1; load_address = IDX_W'(i); load_data = 32'h0010_0093 + i;
         @(negedge clk);
         if (i < 2) begin
            n_tests++;
            if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 ||
                bus.rsp_error !== 1'b0 || dut.outstanding_q !== '0) begin
               n_fail++;
               $display("FAIL reset_values: got rdy=%b v=%b d=%h e=%b out=%0d, required all 0",
                        bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_error, dut.outstanding_q);
            end
         end
         tick();
      end
      load_enable = 0;
      rst = 0;
      @(negedge clk);
      n_tests++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: got %b, required 1", bus.req_ready);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      bit ok;
      int base;
      clear_log();
      base = n_rsp;
      bus.rsp_ready = 1;
      for (int i = 0; i < 8; i++) begin
         bus.req_valid = 1; bus.req_addr = 32'(i * 4);
         @(negedge clk);
         n_tests++;
         if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: cycle %0d got %b, required 1", i, bus.req_ready);
         end
         tick();
      end
      bus.req_valid = 0;
      wait_drain(ok);
      n_tests++;
      if (!ok || n_rsp - base != 8) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d responses, required 8", n_rsp - base);
      end
      n_tests++;
      if (first_rsp - first_acc != LATENCY) begin
         n_fail++;
         $display("FAIL b2b_latency: got %0d cycles, required %0d", first_rsp - first_acc, LATENCY);
      end
      n_tests++;
      if (log_data.size() < 8 || log_data[0] !== 32'h0010_0093 || log_data[7] !== 32'h0010_009A) begin
         n_fail++;
         $display("FAIL b2b_words: got first=%h last=%h, required 00100093 0010009a",
                  log_data.size() > 0 ? log_data[0] : 32'hx, log_data.size() > 7 ? log_data[7] : 32'hx);
      end
   endtask

   task automatic test_backpressure();
      bit ok, acc;
      int k, base;
      clear_log();
      base = n_rsp;
      bus.rsp_ready = 0;
      bus.req_valid = 1; bus.req_addr = 0;
      k = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         acc = bus.req_valid && bus.req_ready;
         if (acc) k++;
         tick();
         if (acc) bus.req_addr = 32'((k % 8) * 4);
      end
      @(negedge clk);
      n_tests++;
      if (k != QD || bus.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_accepts: got %0d accepts rdy=%b, required %0d rdy=0", k, bus.req_ready, QD);
      end
      tick();
      bus.req_valid = 0;
      bus.rsp_ready = 1;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_ready_return: got %b, required 1", bus.req_ready);
      end
      tick();
      wait_drain(ok);
      n_tests++;
      if (!ok || n_rsp - base != QD) begin
         n_fail++;
         $display("FAIL bp_drain: got %0d responses, required %0d", n_rsp - base, QD);
      end
   endtask

   task automatic test_errors();
      bit ok;
      logic [W-1:0] addrs [3];
      addrs[0] = 32'h6; addrs[1] = 32'(4 * DEPTH); addrs[2] = 32'h0;
      clear_log();
      bus.rsp_ready = 1;
      for (int i = 0; i < 3; i++) begin
         bus.req_valid = 1; bus.req_addr = addrs[i];
         tick();
      end
      bus.req_valid = 0;
      wait_drain(ok);
      n_tests++;
      if (!ok || log_data.size() != 3 || log_data[0] !== NOP || log_err[0] !== 1'b1 ||
          log_data[1] !== NOP || log_err[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL err_rsp: got %0d rsps, required two NOP with error", log_data.size());
      end
      n_tests++;
      if (log_err.size() < 3 || log_err[2] !== 1'b0 || log_data[2] !== 32'h0010_0093) begin
         n_fail++;
         $display("FAIL err_then_ok: got e=%b d=%h, required e=0 d=00100093",
                  log_err.size() > 2 ? log_err[2] : 1'bx, log_data.size() > 2 ? log_data[2] : 32'hx);
      end
   endtask

   task automatic test_read_before_write();
      bit ok;
      clear_log();
      bus.rsp_ready = 1;
      load_enable = 1; load_address = 3; load_data = 32'hDEAD_BEEF;
      bus.req_valid = 1; bus.req_addr = 32'hC;
      tick();
      load_enable = 0;
      tick();
      bus.req_valid = 0;
      wait_drain(ok);
      n_tests++;
      if (!ok || log_data.size() != 2 || log_data[0] !== 32'h0010_0096 || log_data[1] !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL rbw: got %h %h, required 00100096 deadbeef",
                  log_data.size() > 0 ? log_data[0] : 32'hx, log_data.size() > 1 ? log_data[1] : 32'hx);
      end
   endtask

   task automatic test_reset_mid();
      bit ok, seen;
      clear_log();
      bus.rsp_ready = 0;
      for (int i = 1; i <= 3; i++) begin
         bus.req_valid = 1; bus.req_addr = 32'(i * 4);
         tick();
      end
      bus.req_valid = 0;
      tick();
      rst = 1;
      tick();
      rst = 0;
      bus.rsp_ready = 1;
      @(negedge clk);
      n_tests++;
      if (bus.req_ready !== 1'b1 || dut.outstanding_q !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_state: got rdy=%b out=%0d, required rdy=1 out=0",
                  bus.req_ready, dut.outstanding_q);
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.rsp_valid) seen = 1;
         @(negedge clk);
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL mid_reset_flush: got rsp_valid after reset, required none");
      end
      tick();
      bus.req_valid = 1; bus.req_addr = 32'h4;
      tick();
      bus.req_addr = 32'hC;
      tick();
      bus.req_valid = 0;
      wait_drain(ok);
      n_tests++;
      if (!ok || log_data.size() != 2 || log_data[0] !== 32'h0010_0094 || log_data[1] !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL mid_reset_mem: got %0d rsps, required 00100094 deadbeef", log_data.size());
      end
   endtask

   initial begin
      rst = 1; load_enable = 0; load_address = '0; load_data = '0;
      bus.req_valid = 0; bus.req_addr = '0; bus.rsp_ready = 1;
      tick();
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_errors();
      test_read_before_write();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/instruction_memory.md
# instruction_memory

Instruction memory responder: the other end of the fetch interface. It accepts word-fetch requests from the fetch stage over a valid/ready handshake. It returns instruction words in order after a fixed pipeline latency, with a bounded response queue that absorbs backpressure. A separate load port writes program words, used at boot or by the testbench.

## Interface
- DEPTH, 1024: number of 32-bit instruction words; power of two.
- LATENCY, 2: cycles from request acceptance to earliest response; legal range 1..4.
- QUEUE_DEPTH, LATENCY+1: maximum outstanding requests (accepted, response not yet consumed).
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  1  fetch request valid.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  REGISTER_WIDTH  byte address of the instruction (program counter).
- rsp_valid  output  1  response word valid.
- rsp_ready  input  1  fetch stage consumes the response this cycle.
- rsp_data  output  REGISTER_WIDTH  instruction word.
- rsp_error  output  1  request was misaligned or out of range.
- load_enable  input  1  write load_data into memory.
- load_address  input  $clog2(DEPTH)  word index for the load write.
- load_data  input  REGISTER_WIDTH  word to write.

## Operation
- Accept: a request is taken when req_valid && req_ready. req_ready = !rst && (outstanding < QUEUE_DEPTH). req_ready depends only on registered state, with no combinational path from req_valid or rsp_ready.
- outstanding: a counter, 0..QUEUE_DEPTH.
  - +1 on accept.
  - −1 on response handshake (rsp_valid && rsp_ready).
  - Both in the same cycle: unchanged.
- Address check at acceptance:
  - word index = req_addr[$clog2(DEPTH)+1:2].
  - misaligned if req_addr[1:0] != 0.
  - out of range if any req_addr bit above the index field is 1.
  - Either case: the response carries rsp_error=1 and rsp_data=0x00000013 (NOP); the memory is not read.
- Read: memory is sampled at the acceptance cycle.
  - A load write in the same cycle to the same word is NOT visible to that read (read-before-write).
  - The load is visible to requests accepted on later cycles.
- Pipeline: LATENCY-stage valid/data/error shift register, always advancing. The final stage writes into a QUEUE_DEPTH-entry in-order FIFO.
- Queue sizing: the credit limit guarantees the FIFO never overflows. A push while the FIFO is full is a design error; flag it with an assertion.
- Output: rsp_valid = FIFO non-empty; rsp_data and rsp_error = FIFO head.
  - The head pops on handshake.
  - Outputs are stable while rsp_valid && !rsp_ready.
- Ordering: responses are strictly in acceptance order, one per accepted request, never dropped or duplicated.
- Load port: independent of fetch traffic; takes effect on every cycle load_enable is high, including during rst.
- Memory contents are not cleared by rst.

## Timing
- Reset values, in the same cycle rst is high and the cycle after: req_ready=0, rsp_valid=0, rsp_data=0, rsp_error=0, outstanding=0. Pipeline and FIFO are emptied.
- First cycle after rst falls: req_ready=1.
- Latency: a request accepted at edge T, with empty queue and rsp_ready held high, gives rsp_valid=1 in the cycle after edge T+LATENCY−1. That is exactly LATENCY cycles, and the response is consumed at edge T+LATENCY.
- Throughput: one request and one response per cycle when rsp_ready is held high. req_ready never drops in that case, because the accept and pop cancel.
- Backpressure: with rsp_ready=0, exactly QUEUE_DEPTH requests are accepted, then req_ready=0.
  - req_ready returns to 1 in the cycle after the first pop.
- Reset mid-operation: all in-flight and queued responses are discarded, with no response emitted after reset.
- Simultaneous accept, pop and load: all take effect at the same edge.

## Test plan
- Load words 0..7 with 0x00100093+i, then fetch addresses 0x0..0x1C back-to-back with rsp_ready=1:
  - eight responses in order, the first exactly LATENCY cycles after the first accept.
  - req_ready stays 1.
- Hold rsp_ready=0 and drive req_valid continuously:
  - exactly QUEUE_DEPTH accepts, then req_ready=0.
  - Release rsp_ready: all responses drain in order with no loss.
- Fetch 0x6 (misaligned), then 4*DEPTH (out of range):
  - rsp_data=0x00000013, rsp_error=1 for both.
  - A following aligned fetch of 0x0 returns rsp_error=0.
- Same cycle: load word 3 := 0xDEADBEEF and accept a fetch of 0xC.
  - That fetch returns the old contents.
  - A fetch of 0xC one cycle later returns 0xDEADBEEF.
- Assert rst for 1 cycle with 3 requests outstanding:
  - no rsp_valid afterwards, and outstanding=0.
  - req_ready=1 the cycle after rst falls.
  - Memory contents are preserved on re-fetch.
